// File: rtl/bitbang_pkg.sv
// Shared constants for the multi-channel bit-bang configuration port.
package bitbang_pkg;

    localparam int CTRL_WIDTH = 16;

    localparam logic [11:0] MAGIC_DEFAULT = 12'hFAB;

    localparam logic [3:0] OP_OFF      = 4'd0;
    localparam logic [3:0] OP_WRITE    = 4'd1;
    localparam logic [3:0] OP_SETCH    = 4'd2;
    localparam logic [3:0] OP_READBACK = 4'd3;

endpackage

// File: rtl/bitbang_sync_edge.sv
// Multi-flop synchroniser with one extra stage for rise/fall detection.
module bitbang_sync_edge #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic [STAGES:0] q;

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else begin
            q <= {q[STAGES-1:0], din};
        end
    end

    assign sync = q[STAGES-1];
    assign rise = q[STAGES-1] & ~q[STAGES];
    assign fall = ~q[STAGES-1] & q[STAGES];

endmodule

// File: rtl/bitbang_multi.sv
// Serial 2-wire loader into NUM_CHANNELS parallel words, with
// channel select, serial readback and a sticky error flag.
module bitbang_multi
    import bitbang_pkg::*;
#(
    parameter int          DATA_WIDTH   = 32,
    parameter int          NUM_CHANNELS = 4,
    parameter int          SYNC_STAGES  = 3,
    parameter logic [11:0] MAGIC        = MAGIC_DEFAULT,
    localparam int CH_W =
        (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               s_clk,
    input  logic                               s_data,
    output logic                               s_dout,
    output logic [NUM_CHANNELS*DATA_WIDTH-1:0] data,
    output logic [NUM_CHANNELS-1:0]            strobe,
    output logic                               active,
    output logic [CH_W-1:0]                    channel,
    output logic                               err
);

    logic clk_sync, clk_rise, clk_fall;
    logic dat_sync, dat_rise, dat_fall;

    bitbang_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
        .clk  (clk),
        .reset(reset),
        .din  (s_clk),
        .sync (clk_sync),
        .rise (clk_rise),
        .fall (clk_fall)
    );

    bitbang_sync_edge #(.STAGES(SYNC_STAGES)) u_dat_sync (
        .clk  (clk),
        .reset(reset),
        .din  (s_data),
        .sync (dat_sync),
        .rise (dat_rise),
        .fall (dat_fall)
    );

    logic unused_sink;
    assign unused_sink = ^{clk_sync, dat_rise, dat_fall};

    logic [DATA_WIDTH-1:0]                   sdata;
    logic [CTRL_WIDTH-1:0]                   ctrl;
    logic                                    cmd_chk;
    logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] data_q;
    logic [DATA_WIDTH-1:0]                   rb;

    logic [3:0] op;
    logic       cmd_ok;
    logic       ch_ok;
    logic       do_off, do_write, do_setch;
    logic       do_read, do_bad;

    // cmd_chk limits decode to the cycle after a fresh ctrl shift
    assign op     = ctrl[3:0];
    assign cmd_ok = cmd_chk && (ctrl[CTRL_WIDTH-1:4] == MAGIC);
    assign ch_ok  = sdata < DATA_WIDTH'(NUM_CHANNELS);

    always_comb begin
        do_off   = 1'b0;
        do_write = 1'b0;
        do_setch = 1'b0;
        do_read  = 1'b0;
        do_bad   = 1'b0;
        if (cmd_ok) begin
            unique case (1'b1)
                op == OP_OFF:      do_off   = 1'b1;
                op == OP_WRITE:    do_write = 1'b1;
                op == OP_SETCH:    do_setch = 1'b1;
                op == OP_READBACK: do_read  = 1'b1;
                default:           do_bad   = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sdata   <= '0;
            ctrl    <= '0;
            cmd_chk <= 1'b0;
            data_q  <= '0;
            strobe  <= '0;
            active  <= 1'b0;
            channel <= '0;
            err     <= 1'b0;
            rb      <= '0;
        end else begin
            cmd_chk <= clk_fall;
            strobe  <= '0;
            if (clk_rise) begin
                sdata <= {sdata[DATA_WIDTH-2:0], dat_sync};
            end
            if (clk_fall) begin
                ctrl <= {ctrl[CTRL_WIDTH-2:0], dat_sync};
            end
            if (do_off) begin
                active <= 1'b0;
            end
            if (do_write) begin
                data_q[channel] <= sdata;
                strobe <= NUM_CHANNELS'(1) << channel;
                active <= 1'b1;
            end
            if (do_setch && ch_ok) begin
                channel <= sdata[CH_W-1:0];
            end
            if (do_read && active) begin
                rb <= data_q[channel];
            end else if (clk_fall && !do_read) begin
                rb <= {rb[DATA_WIDTH-2:0], 1'b0};
            end
            if (do_bad || (do_setch && !ch_ok) ||
                (do_read && !active)) begin
                err <= 1'b1;
            end
        end
    end

    assign data   = data_q;
    assign s_dout = rb[DATA_WIDTH-1];

endmodule

// File: tb/tb_bitbang_multi.sv
// Randomised scoreboard bench for bitbang_multi against an
// edge-level behavioural model of the serial protocol.
module tb_bitbang_multi;

    localparam int DW  = 32;
    localparam int NC  = 4;
    localparam int SS  = 3;
    localparam int CHW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              s_clk;
    logic              s_data;
    logic              s_dout;
    logic [NC*DW-1:0]  data;
    logic [NC-1:0]     strobe;
    logic              active;
    logic [CHW-1:0]    channel;
    logic              err;

    always #5 clk = ~clk;

    bitbang_multi #(
        .DATA_WIDTH  (DW),
        .NUM_CHANNELS(NC),
        .SYNC_STAGES (SS),
        .MAGIC       (12'hFAB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .s_clk  (s_clk),
        .s_data (s_data),
        .s_dout (s_dout),
        .data   (data),
        .strobe (strobe),
        .active (active),
        .channel(channel),
        .err    (err)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int            ch;
        logic [DW-1:0] word;
    } wr_t;

    wr_t exp_q[$];

    logic [DW-1:0] m_data[NC];
    logic [DW-1:0] m_sdata;
    logic [DW-1:0] m_rb;
    logic [15:0]   m_ctrl;
    bit            m_active;
    bit            m_err;
    int            m_ch;

    int   half = 8;
    logic last_dout;

    task automatic check(string name,
                         logic [DW-1:0] act,
                         logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h",
                     name, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < NC; i++) m_data[i] = '0;
        m_sdata  = '0;
        m_rb     = '0;
        m_ctrl   = '0;
        m_active = 1'b0;
        m_err    = 1'b0;
        m_ch     = 0;
        exp_q.delete();
    endfunction

    // One falling s_clk edge: shift ctrl and rb, then run any command.
    function automatic void model_fall(bit b);
        m_ctrl = {m_ctrl[14:0], b};
        m_rb   = m_rb << 1;
        if (m_ctrl[15:4] == 12'hFAB) begin
            case (m_ctrl[3:0])
                4'd0: m_active = 1'b0;
                4'd1: begin
                    m_data[m_ch] = m_sdata;
                    exp_q.push_back('{m_ch, m_sdata});
                    m_active = 1'b1;
                end
                4'd2: begin
                    if (m_sdata < NC) m_ch = int'(m_sdata);
                    else m_err = 1'b1;
                end
                4'd3: begin
                    if (m_active) m_rb = m_data[m_ch];
                    else m_err = 1'b1;
                end
                default: m_err = 1'b1;
            endcase
        end
    endfunction

    task automatic pulse(bit d, bit c);
        repeat (half / 2) @(negedge clk);
        s_data = d;
        repeat (half / 2) @(negedge clk);
        s_clk   = 1'b1;
        m_sdata = {m_sdata[DW-2:0], d};
        repeat (half / 2) @(negedge clk);
        s_data = c;
        repeat (half / 2) @(negedge clk);
        last_dout = s_dout;
        check("s_dout", s_dout, m_rb[DW-1]);
        s_clk = 1'b0;
        model_fall(c);
    endtask

    task automatic frame(logic [DW-1:0] d, logic [15:0] c);
        for (int i = 0; i < 32; i++) begin
            pulse(d[31-i], (i >= 16) ? c[31-i] : 1'b0);
        end
        repeat (10) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset  = 1'b1;
        s_clk  = 1'b0;
        s_data = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_state(string tag);
        check({tag, "_active"}, active, m_active);
        check({tag, "_channel"}, channel, m_ch);
        check({tag, "_err"}, err, m_err);
        for (int i = 0; i < NC; i++) begin
            check({tag, "_data"}, data[i*DW +: DW], m_data[i]);
        end
    endtask

    always @(negedge clk) begin
        wr_t e;
        if (!reset && strobe !== '0) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL strobe_unexpected actual=%b required=0",
                         strobe);
            end else begin
                e = exp_q.pop_front();
                check("strobe", strobe, NC'(1) << e.ch);
                check("strobe_data", data[e.ch*DW +: DW], e.word);
            end
        end
    end

    initial begin
        logic [DW-1:0] got;
        logic [DW-1:0] w;
        logic [15:0]   c;
        int            k;

        reset  = 1'b1;
        s_clk  = 1'b0;
        s_data = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check_state("reset");
        check("reset_sdout", s_dout, 1'b0);
        check("reset_strobe", strobe, '0);

        frame(32'hDEADBEEF, 16'hFAB1);
        check_state("t1");
        check("t1_data0", data[31:0], 32'hDEADBEEF);
        check("t1_active", active, 1'b1);
        check("t1_err", err, 1'b0);

        frame(32'd2, 16'hFAB2);
        frame(32'h12345678, 16'hFAB1);
        check_state("t2");
        check("t2_channel", channel, 2'd2);
        check("t2_data2", data[64 +: 32], 32'h12345678);
        check("t2_data0", data[31:0], 32'hDEADBEEF);

        frame(32'd5, 16'hFAB2);
        check("t3_channel", channel, 2'd2);
        check("t3_err", err, 1'b1);
        frame(32'd1, 16'hFAB2);
        frame(32'd2, 16'hFAB2);
        check("t3_err_sticky", err, 1'b1);
        check_state("t3");

        frame(32'd0, 16'hFAB3);
        got = '0;
        for (int i = 0; i < 32; i++) begin
            pulse(1'b0, 1'b0);
            got[31-i] = last_dout;
        end
        check("t4_readback", got, 32'h12345678);
        pulse(1'b0, 1'b0);
        check("t4_tail", last_dout, 1'b0);

        half = 2 * SS + 2;
        w = 32'hCAFE_F00D;
        for (int i = 0; i < 10; i++) pulse(w[31-i], 1'b0);
        repeat (8) @(negedge clk);
        do_reset();
        check_state("t6_reset");
        frame(32'hA5A5_0F0F, 16'hFAB1);
        check("t6_data0", data[31:0], 32'hA5A5_0F0F);
        check("t6_data1", data[63:32], 32'h0);
        check_state("t6");

        frame(32'd0, 16'hFAB0);
        check("t5_active", active, 1'b0);
        check("t5_err_before", err, 1'b0);
        frame(32'd0, 16'hFAB3);
        check("t5_err", err, 1'b1);
        for (int i = 0; i < 4; i++) pulse(1'b0, 1'b0);
        check_state("t5");

        for (int n = 0; n < 40; n++) begin
            half = 4 + 2 * $urandom_range(0, 2);
            k    = $urandom_range(0, 9);
            w    = $urandom;
            if (k < 7) begin
                c = {12'hFAB, 4'($urandom_range(0, 5))};
                if (c[3:0] == 4'd2) w = $urandom_range(0, 6);
            end else if (k < 8) begin
                c = {12'hFAB, 4'($urandom)};
            end else begin
                c = 16'($urandom);
                if (c[15:4] == 12'hFAB) c[15] = 1'b0;
            end
            frame(w, c);
            check_state("rand");
        end

        repeat (20) @(negedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
